// File: rtl/shift_32_pkg.sv
// Shared constants for the sequential 32-bit shifter.
// State encoding and datapath widths.
package shift_32_pkg;

  localparam int WORD = 32;
  localparam int CNTW = 6;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

endpackage

// File: rtl/shift_32_step.sv
// Single-bit shift step: left, or arithmetic right.
// Also returns the bit pushed out of the word.
module shift32_step
  import shift_32_pkg::*;
(
  input  logic [WORD-1:0] word,
  input  logic            right,
  output logic [WORD-1:0] next,
  output logic            bit_out
);

  always_comb begin
    if (right) begin
      next    = {word[WORD-1], word[WORD-1:1]};
      bit_out = word[0];
    end else begin
      next    = {word[WORD-2:0], 1'b0};
      bit_out = word[WORD-1];
    end
  end

endmodule

// File: rtl/shift_32.sv
// Sequential shifter, one bit per clock, ready/done handshake.
// Signed count: positive shifts left, negative shifts right.
module shift_32
  import shift_32_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ready,
  input  logic [CNTW-1:0] shift,
  input  logic [WORD-1:0] in,
  output logic [WORD-1:0] out,
  output logic            done,
  output logic            last_bit
);

  logic [1:0]      state, state_d;
  logic [CNTW-1:0] count, count_d;
  logic [WORD-1:0] out_q, out_d;
  logic            last_q, last_d;
  logic            dir_q, dir_d;

  logic [CNTW-1:0] mag;
  logic [WORD-1:0] step_out;
  logic            step_bit;

  // -32 negates to 6'b100000, which reads back as 32 unsigned
  assign mag = shift[CNTW-1] ? (~shift + 6'd1) : shift;

  shift32_step u_step (
    .word    (out_q),
    .right   (dir_q),
    .next    (step_out),
    .bit_out (step_bit)
  );

  always_comb begin
    state_d = state;
    count_d = count;
    out_d   = out_q;
    last_d  = last_q;
    dir_d   = dir_q;
    unique case (1'b1)
      (state == IDLE): begin
        if (ready) begin
          out_d   = in;
          last_d  = 1'b0;
          count_d = mag;
          dir_d   = shift[CNTW-1];
          state_d = (mag != '0) ? SHIFT : DONE;
        end
      end
      (state == SHIFT): begin
        out_d   = step_out;
        last_d  = step_bit;
        count_d = count - 6'd1;
        if (count == 6'd1)
          state_d = DONE;
      end
      (state == DONE): begin
        if (!ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      out_q  <= '0;
      last_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      out_q  <= out_d;
      last_q <= last_d;
      dir_q  <= dir_d;
    end
  end

  assign out      = out_q;
  assign last_bit = last_q;
  assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_32.sv
// Bench for shift_32: directed plan cases plus random operands,
// checked against an arithmetic shift model.
module tb_shift_32;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [5:0]  shift;
  logic [31:0] in;
  logic [31:0] out;
  logic        done;
  logic        last_bit;

  int vectors;
  int miscompares;

  shift_32 dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .shift    (shift),
    .in       (in),
    .out      (out),
    .done     (done),
    .last_bit (last_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [5:0]  sh,
                        input bit          hold);
    int          s;
    int          n;
    int          edges;
    longint      sx;
    longint      r;
    logic [31:0] exp_o;
    logic        exp_b;
    s = int'($signed(sh));
    n = (s < 0) ? -s : s;
    if (s < 0) begin
      sx    = longint'($signed(a));
      r     = sx >>> n;
      exp_o = r[31:0];
      r     = sx >>> (n - 1);
      exp_b = r[0];
    end else begin
      r     = {32'b0, a};
      r     = r << n;
      exp_o = r[31:0];
      exp_b = (n == 0) ? 1'b0 : r[32];
    end
    @(negedge clk);
    in    = a;
    shift = sh;
    ready = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    in    = $urandom;
    shift = 6'($urandom);
    if (!hold) ready = 1'b0;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk("latency", 64'(edges), 64'(n + 1));
    chk("out", 64'(out), 64'(exp_o));
    chk("last_bit", 64'(last_bit), 64'(exp_b));
    chk("done", 64'(done), 64'd1);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      chk("hold_state", 64'(dut.state), 64'd2);
      chk("hold_out", 64'(out), 64'(exp_o));
      ready = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("idle_state", 64'(dut.state), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    ready = 1'b0;
    shift = '0;
    in    = '0;
    #12;
    chk("rst_state", 64'(dut.state), 64'd0);
    chk("rst_count", 64'(dut.count), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lb", 64'(last_bit), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(32'h0000_0001, 6'd4, 1'b1);
    run_op(32'h0000_0001, 6'd16, 1'b0);
    run_op(32'h1000_0000, 6'd4, 1'b0);
    run_op(32'hFFFF_FFFF, 6'd4, 1'b0);
    run_op(32'h0000_0010, 6'h3C, 1'b0);
    run_op(32'h0000_0010, 6'h3B, 1'b0);
    run_op(32'h0000_0500, 6'h3E, 1'b0);
    run_op(32'h8000_0000, 6'h20, 1'b0);
    run_op(32'h7FFF_FFFF, 6'h20, 1'b1);
    run_op(32'hDEAD_BEEF, 6'd0, 1'b0);
    run_op(32'h1234_5678, 6'd0, 1'b1);
    run_op(32'h8000_0001, 6'd31, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op($urandom, 6'($urandom), 1'($urandom));

    // abort mid-shift
    @(negedge clk);
    in    = 32'hA5A5_A5A5;
    shift = 6'd20;
    ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    ready = 1'b0;
    chk("mid_state", 64'(dut.state), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_state", 64'(dut.state), 64'd0);
    chk("abort_out", 64'(out), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_count", 64'(dut.count), 64'd0);
    chk("abort_lb", 64'(last_bit), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32'h0000_0003, 6'h3F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
